// File: rtl/scan_load_scheduler_if.sv
// Bundle shared by the host row stream, the scheduler and the scan-loaded buffers.
// The master side is the host/loader environment; the slave side is the scheduler.
interface scan_load_scheduler_if #(
    parameter int DATA_WIDTH = 512,
    parameter int NUM_REQ    = 2
);
    logic [NUM_REQ-1:0]    load_req;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic [NUM_REQ-1:0]    scan_en;
    logic                  scan_valid;
    logic [DATA_WIDTH-1:0] scan_in;
    logic [NUM_REQ-1:0]    grant;
    logic [NUM_REQ-1:0]    load_done;
    logic                  busy;

    modport master (
        output load_req, in_valid, in_data,
        input  in_ready, scan_en, scan_valid, scan_in, grant, load_done, busy
    );

    modport slave (
        input  load_req, in_valid, in_data,
        output in_ready, scan_en, scan_valid, scan_in, grant, load_done, busy
    );
endinterface

// File: rtl/scan_load_scheduler.sv
// Round-robin owner of the host row stream: grants one loader at a time, pulses its
// scan_en, forwards exactly NUM_ROWS rows, then pulses its load_done.
module scan_load_scheduler #(
    parameter int DATA_WIDTH = 512,
    parameter int NUM_ROWS   = 128,
    parameter int NUM_REQ    = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    scan_load_scheduler_if.slave bus
);
    localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, START, STREAM, DONE} state_e;

    state_e                state_q, state_d;
    logic [NUM_REQ-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0]      gidx_q, gidx_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [ROW_W-1:0]      row_cnt_q, row_cnt_d;
    logic [DATA_WIDTH-1:0] scan_in_q, scan_in_d;
    logic                  scan_valid_q, scan_valid_d;

    logic                  pick_found;
    logic                  hi_found;
    logic [IDX_W-1:0]      hi_idx, any_idx, pick_idx;

    // Descending scan leaves the lowest requester at/after rr_ptr in hi_idx and the
    // lowest requester overall in any_idx, which is the wrap-around choice.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        any_idx  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.load_req[i]) begin
                any_idx = IDX_W'(i);
                if (i >= int'(rr_ptr_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = IDX_W'(i);
                end
            end
        end
        pick_found = |bus.load_req;
        pick_idx   = hi_found ? hi_idx : any_idx;
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d       = state_q;
        grant_d       = grant_q;
        gidx_d        = gidx_q;
        rr_ptr_d      = rr_ptr_q;
        row_cnt_d     = row_cnt_q;
        scan_in_d     = scan_in_q;
        scan_valid_d  = 1'b0;
        bus.in_ready  = 1'b0;
        bus.scan_en   = '0;
        bus.load_done = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = NUM_REQ'(1) << pick_idx;
                    gidx_d  = pick_idx;
                    state_d = START;
                end
            end
            START: begin
                bus.scan_en = grant_q;
                state_d     = STREAM;
            end
            STREAM: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    scan_in_d    = bus.in_data;
                    scan_valid_d = 1'b1;
                    if (row_cnt_q == ROW_W'(NUM_ROWS - 1)) begin
                        row_cnt_d = '0;
                        state_d   = DONE;
                    end else begin
                        row_cnt_d = row_cnt_q + ROW_W'(1);
                    end
                end
            end
            DONE: begin
                bus.load_done = grant_q;
                rr_ptr_d      = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);
                grant_d       = '0;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            gidx_q       <= '0;
            rr_ptr_q     <= '0;
            row_cnt_q    <= '0;
            // NOTE: the row register is reset too because scan_in must read 0 in reset.
            scan_in_q    <= '0;
            scan_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            gidx_q       <= gidx_d;
            rr_ptr_q     <= rr_ptr_d;
            row_cnt_q    <= row_cnt_d;
            scan_in_q    <= scan_in_d;
            scan_valid_q <= scan_valid_d;
        end
    end

    assign bus.grant      = grant_q;
    assign bus.scan_in    = scan_in_q;
    assign bus.scan_valid = scan_valid_q;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_scan_load_scheduler.sv
// Randomized bench for scan_load_scheduler: a host driver, a loader-side monitor and a
// queue-based reference model of round-robin order and row delivery.
module tb_scan_load_scheduler;
    localparam int DW = 512;
    localparam int NR = 128;
    localparam int NQ = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    scan_load_scheduler_if #(.DATA_WIDTH(DW), .NUM_REQ(NQ)) bus ();

    scan_load_scheduler #(.DATA_WIDTH(DW), .NUM_ROWS(NR), .NUM_REQ(NQ)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic [DW-1:0] host_rows[$];
    int            exp_order[$];
    int            exp_ptr = 0;

    // Monitor state (written only by the monitor; tasks request a clear via clear_seq)
    logic [DW-1:0] got[NQ][$];
    int en_cnt[NQ];
    int done_cnt[NQ];
    int order_q[$];
    int valid_cnt, viol, ready_rise_cnt, ready_rise_bad;
    int cur = 0;
    logic prev_en_any = 1'b0, prev_done_any = 1'b0, prev_ready = 1'b0;
    int clear_seq = 1, seen_seq = 0;

    always @(negedge clock) begin
        if (clear_seq != seen_seq) begin
            seen_seq = clear_seq;
            for (int i = 0; i < NQ; i++) begin
                got[i].delete();
                en_cnt[i]   = 0;
                done_cnt[i] = 0;
            end
            order_q.delete();
            valid_cnt = 0; viol = 0; ready_rise_cnt = 0; ready_rise_bad = 0;
        end
        if (bus.scan_en != '0) begin
            if (!$onehot(bus.scan_en) || bus.scan_en != bus.grant || prev_en_any) viol++;
            for (int i = 0; i < NQ; i++)
                if (bus.scan_en[i]) begin
                    cur = i;
                    en_cnt[i]++;
                    order_q.push_back(i);
                end
        end
        if (bus.load_done != '0) begin
            if (!$onehot(bus.load_done) || bus.load_done != bus.grant || prev_done_any) viol++;
            for (int i = 0; i < NQ; i++)
                if (bus.load_done[i]) done_cnt[i]++;
        end
        if ($countones(bus.grant) > 1) viol++;
        if (bus.scan_valid) begin
            got[cur].push_back(bus.scan_in);
            valid_cnt++;
        end
        if (bus.in_ready && !prev_ready) begin
            ready_rise_cnt++;
            if (!prev_en_any) ready_rise_bad++;
        end
        prev_en_any   = |bus.scan_en;
        prev_done_any = |bus.load_done;
        prev_ready    = bus.in_ready;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic void fill_rows(input int n, input bit ramp);
        host_rows.delete();
        for (int i = 0; i < n; i++) begin
            logic [DW-1:0] r;
            if (ramp) r = DW'(i);
            else for (int w = 0; w < DW / 32; w++) r[w*32 +: 32] = $urandom;
            host_rows.push_back(r);
        end
    endfunction

    // Expected service order: repeatedly take the first pending requester at or after
    // the pointer, then move the pointer just past it.
    function automatic void predict(input logic [NQ-1:0] req);
        logic [NQ-1:0] pend;
        pend = req;
        exp_order.delete();
        while (pend != '0) begin
            for (int k = 0; k < NQ; k++) begin
                int c;
                c = (exp_ptr + k) % NQ;
                if (pend[c]) begin
                    exp_order.push_back(c);
                    pend[c] = 1'b0;
                    exp_ptr = (c + 1) % NQ;
                    break;
                end
            end
        end
    endfunction

    // Number of rows each loader received that differ from the host stream slice it owns.
    function automatic int mem_errors();
        int errs;
        errs = 0;
        for (int k = 0; k < exp_order.size(); k++) begin
            int g;
            g = exp_order[k];
            if (got[g].size() != NR) errs += NR;
            else for (int i = 0; i < NR; i++)
                if (got[g][i] !== host_rows[k*NR + i]) errs++;
        end
        return errs;
    endfunction

    function automatic bit order_matches();
        if (order_q.size() != exp_order.size()) return 1'b0;
        for (int i = 0; i < order_q.size(); i++)
            if (order_q[i] != exp_order[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Host + requester behaviour. Starts and ends just after a rising edge.
    task automatic drive(input logic [NQ-1:0] req, input int mode, input int stop_after,
                         input int withdraw_at, input int max_cycles,
                         output int accepted, output logic overrun_ready);
        int idx;
        logic v, fire;
        logic [NQ-1:0] done_bits;
        idx = 0;
        overrun_ready = 1'b0;
        clear_seq++;
        bus.load_req = req;
        for (int cyc = 0; cyc < max_cycles; cyc++) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 3 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            v = v && (idx < host_rows.size());
            bus.in_valid = v;
            if (v) bus.in_data = host_rows[idx];
            else   bus.in_data = '0;
            @(negedge clock);
            fire = v && bus.in_ready;
            if (v && idx >= NR && bus.in_ready) overrun_ready = 1'b1;
            done_bits = bus.load_done;
            @(posedge clock);
            #1;
            if (fire) idx++;
            bus.load_req = bus.load_req & ~done_bits;
            if (idx == withdraw_at) bus.load_req[0] = 1'b0;
            if (idx >= stop_after) break;
            if (bus.load_req == '0 && !bus.busy && cyc > 2) break;
        end
        bus.in_valid = 1'b0;
        accepted = idx;
    endtask

    task automatic test_reset();
        bus.load_req = '0; bus.in_valid = 1'b0; bus.in_data = '0;
        #1 reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        n_cmp++;
        if ({bus.in_ready, bus.scan_en, bus.scan_valid, bus.grant, bus.load_done, bus.busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want all zero",
                     {bus.in_ready, bus.scan_en, bus.scan_valid, bus.grant, bus.load_done, bus.busy});
        end
        n_cmp++;
        if (bus.scan_in !== '0) begin
            n_fail++;
            $display("FAIL reset_scan_in: got %0h want 0", bus.scan_in);
        end
        @(negedge clock) reset = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = '1;
        repeat (3) @(posedge clock);
        #1;
        n_cmp++;
        if ({bus.busy, bus.in_ready, bus.scan_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_ignores_valid: got %b want 000", {bus.busy, bus.in_ready, bus.scan_valid});
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_arbitration();
        int acc;
        logic ovr;
        for (int round = 0; round < 2; round++) begin
            fill_rows(2 * NR, 1'b0);
            predict(2'b11);
            drive(2'b11, 2, 1 << 30, -1, 800, acc, ovr);
            n_cmp++;
            if (!order_matches() || order_q.size() < 2 || order_q[0] != 0) begin
                n_fail++;
                $display("FAIL arb_order round %0d: got %0d grants first=%0d want %0d grants first=0",
                         round, order_q.size(), (order_q.size() > 0) ? order_q[0] : -1, exp_order.size());
            end
            n_cmp++;
            if (mem_errors() !== 0) begin
                n_fail++;
                $display("FAIL arb_rows round %0d: got %0d bad rows want 0", round, mem_errors());
            end
            n_cmp++;
            if (done_cnt[0] !== 1 || done_cnt[1] !== 1 || viol !== 0) begin
                n_fail++;
                $display("FAIL arb_done round %0d: got done %0d/%0d viol %0d want 1/1 viol 0",
                         round, done_cnt[0], done_cnt[1], viol);
            end
        end
    endtask

    task automatic test_single_load();
        int acc;
        logic ovr;
        fill_rows(NR, 1'b1);
        predict(2'b01);
        drive(2'b01, 0, 1 << 30, -1, 400, acc, ovr);
        n_cmp++;
        if (acc !== NR || valid_cnt !== NR) begin
            n_fail++;
            $display("FAIL single_count: got accepted %0d valid %0d want %0d", acc, valid_cnt, NR);
        end
        n_cmp++;
        if (en_cnt[0] !== 1 || en_cnt[1] !== 0 || ready_rise_cnt !== 1 || ready_rise_bad !== 0) begin
            n_fail++;
            $display("FAIL single_scan_en: got en %0d/%0d rise %0d bad %0d want 1/0 rise 1 bad 0",
                     en_cnt[0], en_cnt[1], ready_rise_cnt, ready_rise_bad);
        end
        n_cmp++;
        if (mem_errors() !== 0) begin
            n_fail++;
            $display("FAIL single_rows: got %0d bad rows want 0", mem_errors());
        end
        n_cmp++;
        if (done_cnt[0] !== 1 || done_cnt[1] !== 0 || viol !== 0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: got done %0d/%0d viol %0d busy %b want 1/0 viol 0 busy 0",
                     done_cnt[0], done_cnt[1], viol, bus.busy);
        end
    endtask

    task automatic test_back_pressure();
        int acc;
        logic ovr;
        fill_rows(NR, 1'b0);
        predict(2'b01);
        drive(2'b01, 1, 1 << 30, -1, 600, acc, ovr);
        n_cmp++;
        if (acc !== NR || valid_cnt !== NR) begin
            n_fail++;
            $display("FAIL bp_count: got accepted %0d valid %0d want %0d", acc, valid_cnt, NR);
        end
        n_cmp++;
        if (mem_errors() !== 0 || done_cnt[0] !== 1) begin
            n_fail++;
            $display("FAIL bp_rows: got %0d bad rows done %0d want 0 bad done 1", mem_errors(), done_cnt[0]);
        end
    endtask

    task automatic test_overrun();
        int acc, acc2;
        logic ovr, ovr2;
        fill_rows(NR + 2, 1'b0);
        predict(2'b01);
        drive(2'b01, 0, 1 << 30, -1, 400, acc, ovr);
        n_cmp++;
        if (acc !== NR || ovr !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_accept: got accepted %0d ready_on_extra %b want %0d and 0", acc, ovr, NR);
        end
        n_cmp++;
        if (mem_errors() !== 0 || done_cnt[0] !== 1) begin
            n_fail++;
            $display("FAIL overrun_rows: got %0d bad rows done %0d want 0 bad done 1", mem_errors(), done_cnt[0]);
        end
        drive(2'b00, 0, 1 << 30, -1, 8, acc2, ovr2);
        n_cmp++;
        if (acc2 !== 0 || valid_cnt !== 0) begin
            n_fail++;
            $display("FAIL overrun_idle: got accepted %0d valid %0d without grant want 0", acc2, valid_cnt);
        end
    endtask

    task automatic test_withdraw();
        int acc;
        logic ovr;
        fill_rows(NR, 1'b0);
        predict(2'b01);
        drive(2'b01, 2, 1 << 30, 10, 800, acc, ovr);
        n_cmp++;
        if (acc !== NR || mem_errors() !== 0) begin
            n_fail++;
            $display("FAIL withdraw_rows: got accepted %0d bad %0d want %0d bad 0", acc, mem_errors(), NR);
        end
        n_cmp++;
        if (done_cnt[0] !== 1 || en_cnt[0] !== 1) begin
            n_fail++;
            $display("FAIL withdraw_done: got done %0d en %0d want 1 1", done_cnt[0], en_cnt[0]);
        end
    endtask

    task automatic test_reset_mid();
        int acc;
        logic ovr;
        fill_rows(NR, 1'b0);
        drive(2'b01, 0, 50, -1, 200, acc, ovr);
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({bus.in_ready, bus.scan_en, bus.scan_valid, bus.grant, bus.load_done, bus.busy} !== '0
            || bus.scan_in !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got ctrl %b scan_in %0h want all zero",
                     {bus.in_ready, bus.scan_en, bus.scan_valid, bus.grant, bus.load_done, bus.busy}, bus.scan_in);
        end
        bus.load_req = '0;
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b1;
        @(posedge clock);
        #1;
        n_cmp++;
        if (acc !== 50 || done_cnt[0] !== 0 || done_cnt[1] !== 0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_abort: got accepted %0d done %0d/%0d busy %b want 50 0/0 0",
                     acc, done_cnt[0], done_cnt[1], bus.busy);
        end
        exp_ptr = 0;
        fill_rows(NR, 1'b0);
        predict(2'b10);
        drive(2'b10, 2, 1 << 30, -1, 800, acc, ovr);
        n_cmp++;
        if (acc !== NR || mem_errors() !== 0 || !order_matches()) begin
            n_fail++;
            $display("FAIL reset_mid_reload: got accepted %0d bad %0d grants %0d want %0d 0 1",
                     acc, mem_errors(), order_q.size(), NR);
        end
        n_cmp++;
        if (done_cnt[1] !== 1 || done_cnt[0] !== 0 || en_cnt[1] !== 1 || viol !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_done: got done %0d/%0d en1 %0d viol %0d want 0/1 1 0",
                     done_cnt[0], done_cnt[1], en_cnt[1], viol);
        end
    endtask

    initial begin
        test_reset();
        test_arbitration();
        test_single_load();
        test_back_pressure();
        test_overrun();
        test_withdraw();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
